// File: rtl/alu_share_arbiter_if.sv
// Requester / shared-ALU handshake bundle for alu_share_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface alu_share_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 32,
    parameter int unsigned PW   = 33,
    parameter int unsigned IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              hold;
    logic [W-1:0]      alu_a;
    logic [W-1:0]      alu_b;
    logic              alu_ce;
    logic [PW-1:0]     alu_p;
    logic [NREQ-1:0]   rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [PW-1:0]     rsp_data;
    logic              busy;

    modport slave (
        input  req_valid, req_a, req_b, hold, alu_p,
        output req_ready, alu_a, alu_b, alu_ce, rsp_valid, rsp_id, rsp_data, busy
    );

    modport master (
        output req_valid, req_a, req_b, hold, alu_p,
        input  req_ready, alu_a, alu_b, alu_ce, rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one pipelined adder among NREQ requesters.
// A tag pipeline matched to the ALU latency routes each result to its owner.
module alu_share_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 32,
    parameter int unsigned PW   = 33,
    parameter int unsigned LAT  = 2,
    parameter int unsigned IDW  = 2
) (
    input  logic               clk,
    input  logic               rst,
    alu_share_arbiter_if.slave bus
);
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [LAT-1:0]  tag_v_q, tag_v_d;
    logic [IDW-1:0]  tag_id_q [LAT];
    logic [IDW-1:0]  tag_id_d [LAT];

    logic            ce;
    logic            grant_vld;
    logic            accept;
    logic [IDW-1:0]  grant_id;
    logic [IDW-1:0]  cand_id;
    int unsigned     cand;
    logic            rsp_vld;
    logic [PW-1:0]   rsp_data_w;

    assign ce      = ~bus.hold & ~rst;
    assign accept  = grant_vld & ce;
    assign bus.alu_ce = ce;

    // Round-robin search: first valid requester at or above ptr, with wrap.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        cand      = 0;
        cand_id   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_id = cand[IDW-1:0];
            if (!grant_vld && bus.req_valid[cand_id]) begin
                grant_vld = 1'b1;
                grant_id  = cand_id;
            end
        end
    end

    // One-hot grant and operand mux; a bubble (zero operands) when nothing is accepted.
    always_comb begin
        bus.req_ready = '0;
        bus.alu_a     = '0;
        bus.alu_b     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (accept && grant_id == IDW'(i)) begin
                bus.req_ready[i] = 1'b1;
                bus.alu_a        = bus.req_a[i*W +: W];
                bus.alu_b        = bus.req_b[i*W +: W];
            end
        end
    end

    // Next pointer and tag pipeline; everything freezes on cycles without ce.
    always_comb begin
        ptr_d    = ptr_q;
        tag_v_d  = tag_v_q;
        tag_id_d = tag_id_q;
        if (accept) begin
            ptr_d = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
        end
        if (ce) begin
            tag_v_d[0]  = accept;
            tag_id_d[0] = grant_id;
            for (int unsigned k = 1; k < LAT; k++) begin
                tag_v_d[k]  = tag_v_q[k-1];
                tag_id_d[k] = tag_id_q[k-1];
            end
        end
    end

    // State registers; reset drops all in-flight tags so their results are never reported.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q    <= '0;
            tag_v_q  <= '0;
            tag_id_q <= '{default: '0};
        end else begin
            ptr_q    <= ptr_d;
            tag_v_q  <= tag_v_d;
            tag_id_q <= tag_id_d;
        end
    end

    assign rsp_vld    = tag_v_q[LAT-1] & ~bus.hold;
    assign rsp_data_w = bus.alu_p;

    // Result strobe decoded from the last tag stage.
    always_comb begin
        bus.rsp_valid = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (rsp_vld && tag_id_q[LAT-1] == IDW'(i)) begin
                bus.rsp_valid[i] = 1'b1;
            end
        end
    end

    assign bus.rsp_id   = tag_id_q[LAT-1];
    assign bus.rsp_data = rsp_data_w;
    assign bus.busy     = (|tag_v_q) | (|bus.req_valid);
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a two-stage adder model as the shared ALU.
module tb_alu_share_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [32:0] alu_s1 = '0;
    logic [32:0] alu_s2 = '0;
    logic [32:0] fair_sum [4];

    alu_share_arbiter_if #(.NREQ(4), .W(32), .PW(33), .IDW(2)) bus ();

    alu_share_arbiter #(.NREQ(4), .W(32), .PW(33), .LAT(2), .IDW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Shared ALU model: sign-extended add, two ce-enabled stages.
    always @(posedge clk) begin
        if (bus.alu_ce) begin
            alu_s1 <= {bus.alu_a[31], bus.alu_a} + {bus.alu_b[31], bus.alu_b};
            alu_s2 <= alu_s1;
        end
    end
    assign bus.alu_p = alu_s2;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic set_op(input int unsigned i, input logic [31:0] a, input logic [31:0] b);
        bus.req_a[i*32 +: 32] = a;
        bus.req_b[i*32 +: 32] = b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fair_sum[0] = 33'd9;
        fair_sum[1] = 33'd18;
        fair_sum[2] = 33'd27;
        fair_sum[3] = 33'd36;

        bus.req_valid = 4'hF;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.hold      = 1'b0;
        rst           = 1'b1;

        // Reset: no grants while rst, clean state afterwards
        tick();
        settle();
        check_eq("rst_ready", bus.req_ready, 4'h0);
        check_eq("rst_ce", bus.alu_ce, 1'b0);
        tick();
        rst = 1'b0;
        bus.req_valid = 4'h0;
        settle();
        check_eq("post_rst_ready", bus.req_ready, 4'h0);
        check_eq("post_rst_rsp_valid", bus.rsp_valid, 4'h0);
        check_eq("post_rst_rsp_id", bus.rsp_id, 2'd0);
        check_eq("post_rst_busy", bus.busy, 1'b0);
        check_eq("post_rst_ce", bus.alu_ce, 1'b1);

        // Single request from requester 1: 5 + -7
        tick();
        bus.req_valid = 4'b0010;
        set_op(1, 32'd5, 32'hFFFF_FFF9);
        settle();
        check_eq("single_ready", bus.req_ready, 4'b0010);
        check_eq("single_alu_a", bus.alu_a, 32'd5);
        check_eq("single_alu_b", bus.alu_b, 32'hFFFF_FFF9);
        tick();
        bus.req_valid = 4'h0;
        settle();
        check_eq("single_rsp_early", bus.rsp_valid, 4'h0);
        check_eq("single_busy", bus.busy, 1'b1);
        check_eq("single_bubble_a", bus.alu_a, 32'd0);
        tick();
        settle();
        check_eq("single_rsp_valid", bus.rsp_valid, 4'b0010);
        check_eq("single_rsp_id", bus.rsp_id, 2'd1);
        check_eq("single_rsp_data", bus.rsp_data, 33'h1_FFFF_FFFE);
        tick();
        settle();
        check_eq("single_rsp_late", bus.rsp_valid, 4'h0);

        // Fairness: all four valid for 8 cycles after a fresh reset
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        set_op(0, 32'd10, 32'hFFFF_FFFF);
        set_op(1, 32'd20, 32'hFFFF_FFFE);
        set_op(2, 32'd30, 32'hFFFF_FFFD);
        set_op(3, 32'd40, 32'hFFFF_FFFC);
        for (int k = 0; k < 10; k++) begin
            bus.req_valid = (k < 8) ? 4'hF : 4'h0;
            settle();
            check_eq("fair_grant", bus.req_ready, (k < 8) ? 64'(1 << (k % 4)) : 64'd0);
            if (k >= 2) begin
                check_eq("fair_rsp_valid", bus.rsp_valid, 64'(1 << ((k - 2) % 4)));
                check_eq("fair_rsp_id", bus.rsp_id, 64'((k - 2) % 4));
                check_eq("fair_rsp_data", bus.rsp_data, fair_sum[(k - 2) % 4]);
            end else begin
                check_eq("fair_rsp_idle", bus.rsp_valid, 4'h0);
            end
            tick();
        end

        // Extremes on requester 0, back-to-back
        bus.req_valid = 4'b0001;
        set_op(0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        settle();
        check_eq("ext_ready0", bus.req_ready, 4'b0001);
        tick();
        set_op(0, 32'h8000_0000, 32'h8000_0000);
        settle();
        check_eq("ext_ready1", bus.req_ready, 4'b0001);
        tick();
        bus.req_valid = 4'h0;
        settle();
        check_eq("ext_max_valid", bus.rsp_valid, 4'b0001);
        check_eq("ext_max_data", bus.rsp_data, 33'h0_FFFF_FFFE);
        tick();
        settle();
        check_eq("ext_min_valid", bus.rsp_valid, 4'b0001);
        check_eq("ext_min_data", bus.rsp_data, 33'h1_0000_0000);
        tick();

        // Hold mid-flight: accept 3+4 on req0, then hold 3 cycles
        bus.req_valid = 4'b0001;
        set_op(0, 32'd3, 32'd4);
        settle();
        check_eq("hold_accept", bus.req_ready, 4'b0001);
        tick();
        for (int h = 0; h < 3; h++) begin
            bus.hold = 1'b1;
            bus.req_valid = 4'hF;
            settle();
            check_eq("hold_ready", bus.req_ready, 4'h0);
            check_eq("hold_rsp", bus.rsp_valid, 4'h0);
            check_eq("hold_ce", bus.alu_ce, 1'b0);
            check_eq("hold_busy", bus.busy, 1'b1);
            tick();
        end
        bus.hold = 1'b0;
        bus.req_valid = 4'h0;
        settle();
        check_eq("hold_release_rsp", bus.rsp_valid, 4'h0);
        tick();
        settle();
        check_eq("hold_rsp_valid", bus.rsp_valid, 4'b0001);
        check_eq("hold_rsp_data", bus.rsp_data, 33'd7);
        tick();
        settle();
        check_eq("hold_nodup", bus.rsp_valid, 4'h0);
        tick();

        // Reset mid-flight: accept req2 then req3, reset, in-flight results dropped
        bus.req_valid = 4'b0100;
        set_op(2, 32'd100, 32'd1);
        settle();
        check_eq("rmf_ready2", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid = 4'b1000;
        set_op(3, 32'd200, 32'd2);
        settle();
        check_eq("rmf_ready3", bus.req_ready, 4'b1000);
        tick();
        bus.req_valid = 4'h0;
        rst = 1'b1;
        settle();
        check_eq("rmf_rst_ce", bus.alu_ce, 1'b0);
        tick();
        rst = 1'b0;
        bus.req_valid = 4'hF;
        set_op(0, 32'd1, 32'd1);
        settle();
        check_eq("rmf_rsp_gone0", bus.rsp_valid, 4'h0);
        check_eq("rmf_ptr_zero", bus.req_ready, 4'b0001);
        tick();
        bus.req_valid = 4'h0;
        settle();
        check_eq("rmf_rsp_gone1", bus.rsp_valid, 4'h0);
        tick();
        settle();
        check_eq("rmf_new_valid", bus.rsp_valid, 4'b0001);
        check_eq("rmf_new_data", bus.rsp_data, 33'd2);
        tick();

        // Pointer wrap: req3 alone, then req0|req3 twice
        bus.req_valid = 4'b1000;
        settle();
        check_eq("wrap_g3", bus.req_ready, 4'b1000);
        tick();
        bus.req_valid = 4'b1001;
        settle();
        check_eq("wrap_g0", bus.req_ready, 4'b0001);
        tick();
        settle();
        check_eq("wrap_g3b", bus.req_ready, 4'b1000);
        tick();
        bus.req_valid = 4'h0;
        tick();
        tick();
        settle();
        check_eq("drain_busy", bus.busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one pipelined signed 32-bit adder ALU among NREQ requesters.
- Grants at most one operand pair per cycle and drives the ALU operand and clock-enable inputs.
- Tracks which requester owns each in-flight operation with a tag pipeline matched to ALU latency, and steers each result back to its owner.
- Sits between the requester blocks and the shared ALU instance; the ALU itself is external.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 32, operand width.
- PW, 33, result width (W+1).
- LAT, 2, ALU latency in ce-enabled clock edges from operand capture to result on alu_p (≥1).
- IDW, 2, requester id width (clog2(NREQ), minimum 1).

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset; synchronous, active-high.
- req_valid, input, NREQ, per-requester operand pair valid.
- req_ready, output, NREQ, one-hot grant; the transfer occurs when req_valid[i] & req_ready[i] at posedge.
- req_a, input, NREQ*W, packed signed operand a; requester i occupies bits [i*W +: W].
- req_b, input, NREQ*W, packed signed operand b; same packing as req_a.
- hold, input, 1, stall request from downstream; freezes the ALU and the tag pipeline.
- alu_a, output, W, operand a to the ALU.
- alu_b, output, W, operand b to the ALU.
- alu_ce, output, 1, ALU clock enable.
- alu_p, input, PW, signed ALU result.
- rsp_valid, output, NREQ, one-hot result strobe, one cycle per result.
- rsp_id, output, IDW, owner of the current result.
- rsp_data, output, PW, result; equals alu_p.
- busy, output, 1, high when any in-flight tag is valid or any req_valid is high.

Behaviour:
- Reset (clk edge with rst=1):
  - tag pipeline cleared (all valid bits 0); rr pointer = 0.
  - Next cycle: req_ready=0, rsp_valid=0, rsp_id=0.
  - Reset mid-operation discards in-flight results; no rsp_valid follows for them.
- alu_ce = ~hold & ~rst. Combinational.
- Grant (combinational):
  - When hold=0 and rst=0, req_ready is one-hot on the first requester with req_valid set, searching upward from ptr with wrap (ptr, ptr+1, … NREQ-1, 0, …).
  - No valid requester → req_ready=0.
  - hold=1 → req_ready=0.
- Operand steering:
  - alu_a and alu_b come from the granted requester (combinational mux).
  - No grant → alu_a=0, alu_b=0 (issues a bubble; the result is ignored).
- Pointer update: on an accepting edge, ptr ← granted id + 1, modulo NREQ. Otherwise ptr is unchanged.
- Tag pipeline:
  - LAT stages of {v, id}, advancing only on edges with alu_ce=1.
  - Stage 0 loads {accept, granted id}; stage k loads stage k-1.
- Response (combinational from the last stage):
  - rsp_valid[id] = v_last & ~hold.
  - rsp_id = id_last; rsp_data = alu_p.
  - A result whose owner was accepted at edge T appears in the cycle after the LAT-th ce-enabled edge counted from T (T itself counts as edge 1).
  - With no hold, the result for an accept at edge T is visible between edges T+LAT-1 and T+LAT.
- Hold: while hold=1, no accepts, no pipeline movement, and rsp_valid=0. The pending result is re-presented when hold drops; it is neither lost nor duplicated.
- Simultaneous events:
  - Accept and response may occur in the same cycle.
  - The same requester may be granted in consecutive cycles only if no other requester is valid.
- Throughput: 1 op/cycle sustained; responses are returned in acceptance order.
- Arithmetic: no width changes in this block; sign extension and overflow belong to the ALU (PW=W+1 makes the sum exact).

Test Plan:
- Single request: rst 2 cycles, req_valid[1]=1 with a=5, b=-7 for one accept (bench ALU model LAT=2, p=a+b) → req_ready=0010 on the accept cycle; rsp_valid=0010, rsp_id=1, rsp_data=-2 one cycle later; rsp_valid=0 otherwise.
- Fairness: all 4 requesters held valid for 8 cycles → grant order 0,1,2,3,0,1,2,3; each rsp_data matches its own a+b; responses stay in acceptance order.
- Extremes: a=b=0x7FFFFFFF → rsp_data=0x0FFFFFFFE. a=b=0x80000000 → rsp_data=0x100000000 (33-bit).
- Hold mid-flight: accept req0 (3+4); hold=1 for 3 cycles starting the cycle after the accept → no grants and rsp_valid=0 during hold; exactly one rsp_valid=0001 with data 7 after release.
- Reset mid-flight: accept req2 and req3 back-to-back, then rst at the next edge → no rsp_valid afterwards; ptr=0 so req0 wins when all request.
- Pointer wrap: only req3 valid, then req0 and req3 both valid → req3 granted, then req0 granted next, then req3.
